// File: rtl/dfs_lut_arbiter.sv
// rtl/dfs_lut_arbiter.sv - round-robin sharing of one DFS lookup BRAM among N_REQ requesters
// Optional single-entry result cache enabled by defining DFS_LUT_ARB_CACHE_EN.
module dfs_lut_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_idx_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]       resp_data_o,
    output logic                        rom_en_o,
    output logic [ADDR_WIDTH-1:0]       rom_addr_o,
    input  logic [DATA_WIDTH-1:0]       rom_data_i
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [PTR_W-1:0]       win;
    logic                   any_req;
    logic [ADDR_WIDTH-1:0]  win_idx;
    logic                   accept;
    logic                   hit;
    logic [DATA_WIDTH-1:0]  hit_data;

    // Scan from the highest offset down so the requester closest to ptr_q wins.
    always_comb begin : arbitrate
        int j;
        j       = 0;
        win     = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_valid_i[PTR_W'(j)]) begin
                win     = PTR_W'(j);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin : index_mux
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) win_idx = req_idx_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Grants are held off while reset is asserted so no handshake is lost to it.
    assign accept = reset && any_req && (state_q == IDLE || state_q == RESP);

`ifdef DFS_LUT_ARB_CACHE_EN
    logic [ADDR_WIDTH-1:0] last_idx_q;
    logic [DATA_WIDTH-1:0] last_data_q;
    logic                  last_vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_idx_q  <= '0;
            last_data_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (state_q == CAPT) begin
            last_idx_q  <= addr_q;
            last_data_q <= rom_data_i;
            last_vld_q  <= 1'b1;
        end
    end

    assign hit      = last_vld_q && (win_idx == last_idx_q);
    assign hit_data = last_data_q;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    gnt_d = win;
                    ptr_d = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    if (hit) begin
                        data_d  = hit_data;
                        state_d = RESP;
                    end else begin
                        addr_d  = win_idx;
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                data_d  = rom_data_i;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin : outputs
        req_ready_o  = '0;
        resp_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i]  = accept && (win == PTR_W'(i));
            resp_valid_o[i] = (state_q == RESP) && (gnt_q == PTR_W'(i));
        end
    end

    assign rom_en_o    = (state_q == READ);
    assign rom_addr_o  = addr_q;
    assign resp_data_o = data_q;

endmodule

// File: tb/tb_dfs_lut_arbiter.sv
// tb/tb_dfs_lut_arbiter.sv - directed self-checking bench for dfs_lut_arbiter
module tb_dfs_lut_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [9:0]  idx_arr [4];
    logic [39:0] req_idx;
    logic [3:0]  req_ready_o;
    logic [3:0]  resp_valid_o;
    logic [17:0] resp_data_o;
    logic        rom_en_o;
    logic [9:0]  rom_addr_o;
    logic [17:0] rom_q;

    int n_tests;
    int n_fail;

    assign req_idx = {idx_arr[3], idx_arr[2], idx_arr[1], idx_arr[0]};

    dfs_lut_arbiter #(.N_REQ(4), .ADDR_WIDTH(10), .DATA_WIDTH(18)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_idx_i   (req_idx),
        .req_ready_o (req_ready_o),
        .resp_valid_o(resp_valid_o),
        .resp_data_o (resp_data_o),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en_o) rom_q <= 18'h01000 + {8'b0, rom_addr_o};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction

    task automatic lookup(input logic [1:0] r, input logic [9:0] idx,
                          output logic [17:0] data, output int lat, output logic [9:0] addr_seen);
        int t0;
        t0 = -1;
        lat = -1;
        data = '0;
        addr_seen = '0;
        @(posedge clk); #1;
        req_valid[r] = 1'b1;
        idx_arr[r] = idx;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (rom_en_o) addr_seen = rom_addr_o;
            if (resp_valid_o[r] && t0 >= 0) begin
                lat = c - t0;
                data = resp_data_o;
            end
            if (req_ready_o[r] && req_valid[r]) begin
                t0 = c;
                @(posedge clk); #1;
                req_valid[r] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] data;
        logic [9:0]  addr;
        int          lat;
        int          served [4];
        logic [1:0]  w;
        logic        seen;

        n_tests = 0;
        n_fail = 0;
        reset = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            idx_arr[i] = '0;
            served[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        check("rst_resp_data", 32'(resp_data_o), 32'h0);
        check("rst_rom_en", 32'(rom_en_o), 32'h0);
        check("rst_rom_addr", 32'(rom_addr_o), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Test 1: single lookup, req 0 idx 5
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        idx_arr[0] = 10'd5;
        @(negedge clk);
        check("t1_ready", 32'(req_ready_o), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_rom_en", 32'(rom_en_o), 32'h1);
        check("t1_rom_addr", 32'(rom_addr_o), 32'h5);
        @(negedge clk);
        check("t1_capt_en", 32'(rom_en_o), 32'h0);
        check("t1_capt_resp", 32'(resp_valid_o), 32'h0);
        @(negedge clk);
        check("t1_resp_valid", 32'(resp_valid_o), 32'h1);
        check("t1_resp_data", 32'(resp_data_o), 32'h01005);
        @(negedge clk);
        check("t1_resp_pulse", 32'(resp_valid_o), 32'h0);
        check("t1_data_hold", 32'(resp_data_o), 32'h01005);

        // Test 2: all four valid from reset, idx 1..4
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) idx_arr[i] = 10'(i + 1);
        @(negedge clk);
        check("t2_ready_in_reset", 32'(req_ready_o), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("t2_grant", 32'(req_ready_o), 32'(onehot(2'(k))));
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
            repeat (3) @(negedge clk);
            check("t2_resp_valid", 32'(resp_valid_o), 32'(onehot(2'(k))));
            check("t2_resp_data", 32'(resp_data_o), 32'h01001 + 32'(k));
        end
        check("t2_no_second_grant", 32'(req_ready_o), 32'h0);

        // Test 3: re-request during RESP, wrap of the pointer, then fairness sweep
        lookup(2'd1, 10'd11, data, lat, addr);
        check("t3_setup_data", 32'(data), 32'h0100B);
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        idx_arr[1] = 10'd12;
        req_valid[2] = 1'b1;
        idx_arr[2] = 10'd13;
        @(negedge clk);
        check("t3_p2_grant", 32'(req_ready_o), 32'h4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        idx_arr[2] = 10'd14;
        @(negedge clk);
        check("t3_resp2_valid", 32'(resp_valid_o), 32'h4);
        check("t3_resp2_data", 32'(resp_data_o), 32'h0100D);
        check("t3_wrap_grant", 32'(req_ready_o), 32'h2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_resp1_data", 32'(resp_data_o), 32'h0100C);
        check("t3_rereq_grant", 32'(req_ready_o), 32'h4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_rereq_data", 32'(resp_data_o), 32'h0100E);

        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) idx_arr[i] = 10'(20 + i);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            w = 2'((3 + k) % 4);
            check("t3_sweep_grant", 32'(req_ready_o), 32'(onehot(w)));
            for (int i = 0; i < 4; i++) if (req_ready_o[i]) served[i]++;
            if (k == 15) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
            repeat (3) @(negedge clk);
            check("t3_sweep_resp", 32'(resp_valid_o), 32'(onehot(w)));
            check("t3_sweep_data", 32'(resp_data_o), 32'h01014 + 32'(w));
        end
        for (int i = 0; i < 4; i++) check("t3_served_count", 32'(served[i]), 32'd4);

        // Test 4: reset asserted while idx 9 is in CAPT
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        idx_arr[0] = 10'd9;
        @(negedge clk);
        check("t4_grant", 32'(req_ready_o), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t4_rom_en", 32'(rom_en_o), 32'h0);
        check("t4_rom_addr", 32'(rom_addr_o), 32'h0);
        check("t4_resp_valid", 32'(resp_valid_o), 32'h0);
        check("t4_resp_data", 32'(resp_data_o), 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid_o != 4'b0 || rom_en_o) seen = 1'b1;
        end
        check("t4_no_pulse", 32'(seen), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        lookup(2'd0, 10'd9, data, lat, addr);
        check("t4_reissue_data", 32'(data), 32'h01009);
        check("t4_reissue_lat", 32'(lat), 32'd3);

        // Test 5: top-of-range index
        lookup(2'd3, 10'h3FF, data, lat, addr);
        check("t5_rom_addr", 32'(addr), 32'h3FF);
        check("t5_data", 32'(data), 32'h013FF);
        check("t5_lat", 32'(lat), 32'd3);

        // Test 6: the same index twice back-to-back
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        idx_arr[0] = 10'd7;
        @(negedge clk);
        check("t6_first_grant", 32'(req_ready_o), 32'h1);
        repeat (3) @(negedge clk);
        check("t6_first_resp", 32'(resp_valid_o), 32'h1);
        check("t6_first_data", 32'(resp_data_o), 32'h01007);
        check("t6_second_grant", 32'(req_ready_o), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
`ifdef DFS_LUT_ARB_CACHE_EN
        check("t6_hit_rom_en", 32'(rom_en_o), 32'h0);
        check("t6_hit_resp", 32'(resp_valid_o), 32'h1);
        check("t6_hit_data", 32'(resp_data_o), 32'h01007);
`else
        check("t6_miss_rom_en", 32'(rom_en_o), 32'h1);
        check("t6_miss_early_resp", 32'(resp_valid_o), 32'h0);
        repeat (2) @(negedge clk);
        check("t6_miss_resp", 32'(resp_valid_o), 32'h1);
        check("t6_miss_data", 32'(resp_data_o), 32'h01007);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
